// File: rtl/matrix_unpack_tx.sv
// Compacts a 5x5 padded 8-bit result matrix to its active NxN size and streams
// it row-major as 32-bit words (4 elements per word) over valid/ready.
module matrix_unpack_tx #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5,
  parameter int WORD_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                size,
  input  logic [DIM*DIM*ELEM_W-1:0] matrix_in,
  output logic                      busy,
  output logic [WORD_W-1:0]         word_out,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic                      word_last,
  output logic                      done
);

  localparam int MAT_W  = DIM * DIM * ELEM_W;
  localparam int PER_W  = WORD_W / ELEM_W;
  localparam int N_WORD = (DIM * DIM + PER_W - 1) / PER_W;
  localparam int N_ELEM = N_WORD * PER_W;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  typedef logic [0:N_WORD-1][WORD_W-1:0] img_t;

  // Compact image: element (r,c) of the active NxN block lands at byte r*N+c,
  // unused tail bytes stay zero so the final word is zero-padded.
  function automatic img_t pack(input logic [MAT_W-1:0] m, input logic [1:0] sz);
    logic [0:N_ELEM-1][ELEM_W-1:0] b;
    b = '0;
    for (int s = 0; s < 4; s++) begin
      if (sz == 2'(s)) begin
        for (int r = 0; r < s + 2; r++) begin
          for (int c = 0; c < s + 2; c++) begin
            b[5'(r * (s + 2) + c)] = m[8'(MAT_W - 1 - ELEM_W * (DIM * r + c)) -: ELEM_W];
          end
        end
      end
    end
    return b;
  endfunction

  // Index of the final word for each size: ceil(N*N/4) - 1.
  function automatic logic [2:0] last_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd0;
      2'b01:   return 3'd2;
      2'b10:   return 3'd3;
      default: return 3'd6;
    endcase
  endfunction

  state_t     state;
  img_t       image;
  img_t       start_image;
  logic [2:0] idx;
  logic [2:0] last_idx;
  logic [2:0] next_idx;

  assign start_image = pack(matrix_in, size);
  assign next_idx    = idx + 3'd1;

  // NOTE: every register here, including the latched image, is assigned with
  // non-blocking <= and cleared on reset so an aborted transfer leaves no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      image      <= '0;
      idx        <= '0;
      last_idx   <= '0;
      busy       <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            image      <= start_image;
            idx        <= 3'd0;
            last_idx   <= last_of(size);
            word_out   <= start_image[0];
            word_valid <= 1'b1;
            word_last  <= (size == 2'b00);
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (word_ready) begin
            if (idx == last_idx) begin
              word_out   <= '0;
              word_valid <= 1'b0;
              word_last  <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              idx       <= next_idx;
              word_out  <= image[next_idx];
              word_last <= (next_idx == last_idx);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_unpack_tx.sv
// Directed bench for matrix_unpack_tx: sizes 2x2..5x5, back-pressure, ignored
// mid-transfer start, asynchronous reset abort.
module tb_matrix_unpack_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   size;
  logic [199:0] matrix_in;
  logic         busy;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic         word_last;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic [199:0] base_mat;
  logic [31:0]  exp2 [7];
  logic [31:0]  exp3 [7];
  logic [31:0]  exp4 [7];
  logic [31:0]  exp5 [7];

  matrix_unpack_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .size       (size),
    .matrix_in  (matrix_in),
    .busy       (busy),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, " busy"},  32'(busy), 32'd0);
    check({tag, " valid"}, 32'(word_valid), 32'd0);
    check({tag, " last"},  32'(word_last), 32'd0);
    check({tag, " done"},  32'(done), 32'd0);
    check({tag, " word"},  word_out, 32'd0);
  endtask

  // Called at a negedge; the first word is presented at the next negedge.
  task automatic run_start(input logic [1:0] sz);
    start = 1'b1;
    size  = sz;
    @(negedge clk);
    start = 1'b0;
  endtask

  // With ready high, check n consecutive words, then the done cycle and return to idle.
  task automatic expect_words(input string tag, input int n, input logic [31:0] exp [7]);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s w%0d valid", tag, i), 32'(word_valid), 32'd1);
      check($sformatf("%s w%0d busy", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s w%0d data", tag, i), word_out, exp[i]);
      check($sformatf("%s w%0d last", tag, i), 32'(word_last), 32'(i == n - 1));
      @(negedge clk);
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " done busy"}, 32'(busy), 32'd1);
    check({tag, " done valid"}, 32'(word_valid), 32'd0);
    check({tag, " done word"}, word_out, 32'd0);
    @(negedge clk);
    check({tag, " post done"}, 32'(done), 32'd0);
    check({tag, " post busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        base_mat[199 - 8 * (5 * r + c) -: 8] = 8'(5 * r + c + 1);
    exp2 = '{32'h01020607, 0, 0, 0, 0, 0, 0};
    exp3 = '{32'h01020306, 32'h07080B0C, 32'h0D000000, 0, 0, 0, 0};
    exp4 = '{32'h01020304, 32'h06070809, 32'h0B0C0D0E, 32'h10111213, 0, 0, 0};
    exp5 = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
             32'h11121314, 32'h15161718, 32'h19000000};

    rst_n      = 1'b0;
    start      = 1'b0;
    size       = 2'b00;
    matrix_in  = base_mat;
    word_ready = 1'b0;
    #1;
    idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_outputs("idle");

    // 2x2, then 3x3 back-to-back on the cycle after DONE
    word_ready = 1'b1;
    run_start(2'b00);
    expect_words("s2", 1, exp2);
    run_start(2'b01);
    expect_words("s3", 3, exp3);

    // 4x4 with back-pressure on word 1
    word_ready = 1'b0;
    run_start(2'b10);
    check("s4 w0 data", word_out, exp4[0]);
    check("s4 w0 stall valid", 32'(word_valid), 32'd1);
    @(negedge clk);
    check("s4 w0 held", word_out, exp4[0]);
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s4 w1 hold%0d data", i), word_out, exp4[1]);
      check($sformatf("s4 w1 hold%0d valid", i), 32'(word_valid), 32'd1);
      check($sformatf("s4 w1 hold%0d last", i), 32'(word_last), 32'd0);
      if (i < 3) @(negedge clk);
    end
    word_ready = 1'b1;
    @(negedge clk);
    check("s4 w2 data", word_out, exp4[2]);
    check("s4 w2 last", 32'(word_last), 32'd0);
    @(negedge clk);
    check("s4 w3 data", word_out, exp4[3]);
    check("s4 w3 last", 32'(word_last), 32'd1);
    @(negedge clk);
    check("s4 done", 32'(done), 32'd1);
    @(negedge clk);
    check("s4 post done", 32'(done), 32'd0);

    // 5x5 with a conflicting start/size/matrix pulsed during word 2
    run_start(2'b11);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("s5 w%0d data", i), word_out, exp5[i]);
      check($sformatf("s5 w%0d valid", i), 32'(word_valid), 32'd1);
      check($sformatf("s5 w%0d last", i), 32'(word_last), 32'(i == 6));
      start     = (i == 2);
      size      = (i >= 2) ? 2'b00 : 2'b11;
      matrix_in = (i >= 2) ? ~base_mat : base_mat;
      @(negedge clk);
    end
    start     = 1'b0;
    matrix_in = base_mat;
    check("s5 done", 32'(done), 32'd1);
    @(negedge clk);
    check("s5 post done", 32'(done), 32'd0);
    check("s5 post busy", 32'(busy), 32'd0);

    // Asynchronous reset during word 2 of 5x5
    run_start(2'b11);
    @(negedge clk);
    @(negedge clk);
    check("rst w2 data", word_out, exp5[2]);
    #2;
    rst_n = 1'b0;
    #1;
    idle_outputs("async rst");
    @(negedge clk);
    idle_outputs("rst held");
    rst_n = 1'b1;
    @(negedge clk);
    idle_outputs("rst released");
    run_start(2'b00);
    expect_words("rst s2", 1, exp2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
